cart_mem_arbiter: RTL and testbench

- Sits directly downstream of the mapper modules.
- Takes the mapper-translated PRG and CHR linear addresses (22-bit cart space) and serialises them onto a single external memory port with a req/ack handshake.
- Captures read data per source and holds it stable for the CPU and PPU data buses.
- CHR has priority, since PPU fetch timing is tighter. A starvation guard bounds PRG latency.

---
 rtl/cart_mem_arbiter_pkg.sv | 33 +++
 rtl/cart_mem_arbiter_if.sv | 52 +++++
 rtl/cart_mem_arbiter_slot.sv | 47 ++++
 rtl/cart_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_cart_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cart_mem_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cart_arb_pkg : shared types and constants for cart_mem_arbiter     |
// | Revision 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
package cart_arb_pkg;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} arb_state_e;

  typedef enum logic {SRC_PRG = 1'b0, SRC_CHR = 1'b1} src_e;

  typedef struct packed {
    logic        valid;
    logic [21:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } mem_slot_t;

  localparam logic [3:0] PRG_RAM_TAG = 4'b1111;
  localparam logic [1:0] CHR_RAM_TAG = 2'b10;
  localparam logic [7:0] RDATA_IDLE  = 8'hFF;

  // Reads are always allowed; writes only land in the RAM window of their source.
  function automatic logic write_allowed(input src_e src, input mem_slot_t s);
    if (!s.we)
      return 1'b1;
    if (src == SRC_PRG)
      return s.addr[21:18] == PRG_RAM_TAG;
    return s.addr[21:20] == CHR_RAM_TAG;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cart_mem_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cart_mem_arbiter_if : PRG/CHR request buses and external mem port  |
// | Revision 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
interface cart_mem_arbiter_if;

  logic        prg_req;
  logic [21:0] prg_addr;
  logic        prg_we;
  logic [7:0]  prg_wdata;
  logic [7:0]  prg_rdata;
  logic        prg_busy;

  logic        chr_req;
  logic [21:0] chr_addr;
  logic        chr_we;
  logic [7:0]  chr_wdata;
  logic [7:0]  chr_rdata;
  logic        chr_busy;

  logic        mem_req;
  logic [21:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic [3:0]  err_flags;

  modport master (
    input  prg_req, prg_addr, prg_we, prg_wdata,
    output prg_rdata, prg_busy,
    input  chr_req, chr_addr, chr_we, chr_wdata,
    output chr_rdata, chr_busy,
    output mem_req, mem_addr, mem_we, mem_wdata,
    input  mem_ack, mem_rdata,
    output err_flags
  );

  modport slave (
    output prg_req, prg_addr, prg_we, prg_wdata,
    input  prg_rdata, prg_busy,
    output chr_req, chr_addr, chr_we, chr_wdata,
    input  chr_rdata, chr_busy,
    input  mem_req, mem_addr, mem_we, mem_wdata,
    output mem_ack, mem_rdata,
    input  err_flags
  );

endinterface
`default_nettype wire

// File: rtl/cart_mem_arbiter_slot.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_slot : depth-1 request holding slot with overrun detection     |
// | Revision 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module arb_slot
  import cart_arb_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        reset_n,
  input  wire logic        strobe_i,
  input  wire logic [21:0] addr_i,
  input  wire logic        we_i,
  input  wire logic [7:0]  wdata_i,
  input  wire logic        clear_i,
  output mem_slot_t        slot_o,
  output logic             overrun_o
);

  mem_slot_t slot_q;
  mem_slot_t slot_d;

  // Clear is applied before capture so a completing slot can be refilled in the same cycle.
  always_comb begin
    slot_d    = slot_q;
    overrun_o = 1'b0;
    if (clear_i)
      slot_d.valid = 1'b0;
    if (strobe_i) begin
      if (slot_d.valid)
        overrun_o = 1'b1;
      else
        slot_d = '{valid: 1'b1, addr: addr_i, we: we_i, wdata: wdata_i};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      slot_q <= '0;
    else
      slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule
`default_nettype wire

// File: rtl/cart_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cart_mem_arbiter : CHR-priority PRG/CHR arbiter onto one mem port  |
// | Optional write protection: CART_ARB_WRITE_PROTECT_EN               |
// | Revision 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module cart_mem_arbiter
  import cart_arb_pkg::*;
#(
  parameter int PRG_STARVE_MAX = 3,
  parameter int ACK_TIMEOUT    = 255,
  parameter int TMO_W          = 8
) (
  input wire logic           clk,
  input wire logic           reset_n,
  cart_mem_arbiter_if.master bus
);

  localparam int                  STARVE_W   = $clog2(PRG_STARVE_MAX + 2);
  localparam logic [STARVE_W-1:0] STARVE_SAT = STARVE_W'(PRG_STARVE_MAX);
  localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(ACK_TIMEOUT - 1);

  mem_slot_t prg_slot, chr_slot;
  logic      prg_clr, chr_clr, prg_ovr, chr_ovr;
  logic      pick_chr, grant, wp_ok;
  logic [7:0] rd_val;

  arb_state_e          state_q, state_d;
  src_e                src_q, src_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [21:0]         mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic [7:0]          prg_rdata_q, prg_rdata_d, chr_rdata_q, chr_rdata_d;
  logic [3:0]          err_q, err_d;

  arb_slot u_prg_slot (
    .clk(clk), .reset_n(reset_n),
    .strobe_i(bus.prg_req), .addr_i(bus.prg_addr), .we_i(bus.prg_we), .wdata_i(bus.prg_wdata),
    .clear_i(prg_clr), .slot_o(prg_slot), .overrun_o(prg_ovr)
  );

  arb_slot u_chr_slot (
    .clk(clk), .reset_n(reset_n),
    .strobe_i(bus.chr_req), .addr_i(bus.chr_addr), .we_i(bus.chr_we), .wdata_i(bus.chr_wdata),
    .clear_i(chr_clr), .slot_o(chr_slot), .overrun_o(chr_ovr)
  );

  // CHR wins unless PRG has already been passed over PRG_STARVE_MAX times.
  assign pick_chr = chr_slot.valid && (!prg_slot.valid || (starve_q < STARVE_SAT));

`ifdef CART_ARB_WRITE_PROTECT_EN
  assign wp_ok = write_allowed(pick_chr ? SRC_CHR : SRC_PRG, pick_chr ? chr_slot : prg_slot);
`else
  assign wp_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    prg_rdata_d = prg_rdata_q;
    chr_rdata_d = chr_rdata_q;
    err_d       = err_q | {2'b00, chr_ovr, prg_ovr};
    prg_clr     = 1'b0;
    chr_clr     = 1'b0;
    grant       = 1'b0;
    rd_val      = RDATA_IDLE;

    case (state_q)
      IDLE: begin
        if (prg_slot.valid || chr_slot.valid) begin
          grant = 1'b1;
          src_d = pick_chr ? SRC_CHR : SRC_PRG;
          if (!wp_ok) begin
            // Blocked write is retired from the slot without touching the memory port.
            prg_clr  = !pick_chr;
            chr_clr  = pick_chr;
            err_d[2] = 1'b1;
          end else begin
            state_d     = REQ;
            mem_req_d   = 1'b1;
            mem_addr_d  = pick_chr ? chr_slot.addr  : prg_slot.addr;
            mem_we_d    = pick_chr ? chr_slot.we    : prg_slot.we;
            mem_wdata_d = pick_chr ? chr_slot.wdata : prg_slot.wdata;
          end
        end
      end
      REQ: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.mem_ack || (tmo_q == TMO_LAST)) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          tmo_d     = '0;
          prg_clr   = (src_q == SRC_PRG);
          chr_clr   = (src_q == SRC_CHR);
          if (!bus.mem_ack)
            err_d[3] = 1'b1;
          else
            rd_val = bus.mem_rdata;
          if (!mem_we_q) begin
            if (src_q == SRC_PRG)
              prg_rdata_d = rd_val;
            else
              chr_rdata_d = rd_val;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (!prg_slot.valid)
      starve_d = '0;
    else if (grant && !pick_chr)
      starve_d = '0;
    else if (grant && (starve_q != STARVE_SAT))
      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      src_q       <= SRC_PRG;
      starve_q    <= '0;
      tmo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      prg_rdata_q <= RDATA_IDLE;
      chr_rdata_q <= RDATA_IDLE;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      prg_rdata_q <= prg_rdata_d;
      chr_rdata_q <= chr_rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.prg_rdata = prg_rdata_q;
  assign bus.chr_rdata = chr_rdata_q;
  assign bus.prg_busy  = prg_slot.valid;
  assign bus.chr_busy  = chr_slot.valid;
  assign bus.err_flags = err_q;

endmodule
`default_nettype wire

// File: tb/tb_cart_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_cart_mem_arbiter : scoreboard bench for cart_mem_arbiter        |
// | Revision 1.0 - initial release                                     |
// +--------------------------------------------------------------------+
module tb_cart_mem_arbiter;

`ifdef CART_ARB_WRITE_PROTECT_EN
  localparam logic WP = 1'b1;
`else
  localparam logic WP = 1'b0;
`endif

  typedef struct {
    logic [21:0] addr;
    logic        we;
    logic [7:0]  wdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   resp_delay = 3;
  logic resp_withhold = 1'b0;
  exp_t exp_q[$];

  cart_mem_arbiter_if bus();

  cart_mem_arbiter #(.PRG_STARVE_MAX(3), .ACK_TIMEOUT(255), .TMO_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input logic lvl, input int budget, output int cycles);
    cycles = -1;
    for (int c = 0; c < budget; c++) begin
      if (bus.mem_req == lvl) begin
        cycles = c;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (!bus.prg_busy && !bus.chr_busy && !bus.mem_req)
        return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL %s idle-wait expired actual=busy required=idle", name);
  endtask

  task automatic strobe_prg(input logic [21:0] a, input logic we, input logic [7:0] wd);
    bus.prg_addr = a; bus.prg_we = we; bus.prg_wdata = wd; bus.prg_req = 1'b1;
  endtask

  task automatic strobe_chr(input logic [21:0] a, input logic we, input logic [7:0] wd);
    bus.chr_addr = a; bus.chr_we = we; bus.chr_wdata = wd; bus.chr_req = 1'b1;
  endtask

  // Memory model: ack after resp_delay cycles, read data = addr[7:0] ^ 8'h79.
  initial begin : responder
    int age;
    age = 0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (bus.mem_req) begin
        age++;
        if (age == resp_delay && !resp_withhold) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus.mem_addr[7:0] ^ 8'h79;
        end
      end else begin
        age = 0;
      end
    end
  end

  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.mem_req && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue actual=%0h required=none", bus.mem_addr);
        end else begin
          e = exp_q.pop_front();
          check("issue_addr", 32'(bus.mem_addr), 32'(e.addr));
          check("issue_we", 32'(bus.mem_we), 32'(e.we));
          if (e.we)
            check("issue_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
        end
      end
      prev = bus.mem_req;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int c, n;
    logic [21:0] caddr [4];
    caddr[0] = 22'h200010; caddr[1] = 22'h200011;
    caddr[2] = 22'h200012; caddr[3] = 22'h200013;

    reset_n = 1'b0;
    bus.prg_req = 1'b0; bus.prg_addr = '0; bus.prg_we = 1'b0; bus.prg_wdata = '0;
    bus.chr_req = 1'b0; bus.chr_addr = '0; bus.chr_we = 1'b0; bus.chr_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_mem_addr", 32'(bus.mem_addr), 0);
    check("rst_mem_we", 32'(bus.mem_we), 0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    check("rst_prg_rdata", 32'(bus.prg_rdata), 32'hFF);
    check("rst_chr_rdata", 32'(bus.chr_rdata), 32'hFF);
    check("rst_busy", {30'd0, bus.prg_busy, bus.chr_busy}, 0);
    check("rst_err", 32'(bus.err_flags), 0);
    reset_n = 1'b1;

    // Single PRG read: 0x23 ^ 0x79 = 0x5A
    exp_q.push_back('{22'h000123, 1'b0, 8'h00});
    @(negedge clk); strobe_prg(22'h000123, 1'b0, 8'h00);
    @(negedge clk); bus.prg_req = 1'b0;
    check("t1_busy_next", 32'(bus.prg_busy), 1);
    check("t1_req_1cyc", 32'(bus.mem_req), 0);
    @(negedge clk);
    check("t1_req_2cyc", 32'(bus.mem_req), 1);
    wait_idle("t1", 30);
    check("t1_prg_rdata", 32'(bus.prg_rdata), 32'h5A);
    check("t1_prg_busy", 32'(bus.prg_busy), 0);
    check("t1_chr_rdata", 32'(bus.chr_rdata), 32'hFF);

    // Simultaneous strobes: CHR 0xDE^0x79=0xA7 first, then PRG 0x77^0x79=0x0E
    exp_q.push_back('{22'h2ABCDE, 1'b0, 8'h00});
    exp_q.push_back('{22'h000177, 1'b0, 8'h00});
    @(negedge clk); strobe_chr(22'h2ABCDE, 1'b0, 8'h00); strobe_prg(22'h000177, 1'b0, 8'h00);
    @(negedge clk); bus.prg_req = 1'b0; bus.chr_req = 1'b0;
    wait_req(1'b1, 20, c);
    check("t2_chr_first", 32'(bus.mem_addr), 32'h2ABCDE);
    wait_req(1'b0, 20, c);
    wait_req(1'b1, 20, c);
    check("t2_idle_gap", c, 1);
    wait_idle("t2", 30);
    check("t2_chr_rdata", 32'(bus.chr_rdata), 32'hA7);
    check("t2_prg_rdata", 32'(bus.prg_rdata), 32'h0E);

    // Starvation: CHR refilled on each CHR ack; PRG must follow the third CHR grant
    exp_q.push_back('{caddr[0], 1'b0, 8'h00});
    exp_q.push_back('{caddr[1], 1'b0, 8'h00});
    exp_q.push_back('{caddr[2], 1'b0, 8'h00});
    exp_q.push_back('{22'h000200, 1'b0, 8'h00});
    exp_q.push_back('{caddr[3], 1'b0, 8'h00});
    @(negedge clk); strobe_chr(caddr[0], 1'b0, 8'h00); strobe_prg(22'h000200, 1'b0, 8'h00);
    @(negedge clk); bus.prg_req = 1'b0; bus.chr_req = 1'b0;
    n = 1;
    for (int cyc = 0; cyc < 300 && n < 4; cyc++) begin
      @(negedge clk); #1;
      bus.chr_req = 1'b0;
      if (bus.mem_ack && bus.mem_addr == bus.chr_addr) begin
        strobe_chr(caddr[n], 1'b0, 8'h00);
        n++;
      end
    end
    @(negedge clk); #1 bus.chr_req = 1'b0;
    check("t3_refills", n, 4);
    wait_idle("t3", 60);
    check("t3_no_overrun", 32'(bus.err_flags), 0);
    check("t3_chr_rdata", 32'(bus.chr_rdata), 32'h6A);
    check("t3_prg_rdata", 32'(bus.prg_rdata), 32'h79);

    // Overrun: second PRG strobe dropped, only 0x000345 issued (0x45^0x79=0x3C)
    exp_q.push_back('{22'h000345, 1'b0, 8'h00});
    @(negedge clk); strobe_prg(22'h000345, 1'b0, 8'h00);
    @(negedge clk); strobe_prg(22'h000346, 1'b0, 8'h00);
    @(negedge clk); bus.prg_req = 1'b0;
    check("t4_overrun_flag", 32'(bus.err_flags), 32'h1);
    wait_idle("t4", 30);
    repeat (5) @(negedge clk);
    check("t4_prg_rdata", 32'(bus.prg_rdata), 32'h3C);
    check("t4_queue_drained", exp_q.size(), 0);

    // Writes: outside PRG RAM window, then inside it
    if (!WP) exp_q.push_back('{22'h012345, 1'b1, 8'hC3});
    @(negedge clk); strobe_prg(22'h012345, 1'b1, 8'hC3);
    @(negedge clk); bus.prg_req = 1'b0; bus.prg_we = 1'b0;
    wait_idle("t5a", 30);
    check("t5_wp_flag", 32'(bus.err_flags), WP ? 32'h5 : 32'h1);
    exp_q.push_back('{22'h3C0010, 1'b1, 8'h3C});
    @(negedge clk); strobe_prg(22'h3C0010, 1'b1, 8'h3C);
    @(negedge clk); bus.prg_req = 1'b0; bus.prg_we = 1'b0;
    wait_idle("t5b", 30);
    check("t5_write_keeps_rdata", 32'(bus.prg_rdata), 32'h3C);
    check("t5_queue_drained", exp_q.size(), 0);

    // Ack withheld: mem_req high for exactly 255 cycles
    resp_withhold = 1'b1;
    exp_q.push_back('{22'h000456, 1'b0, 8'h00});
    @(negedge clk); strobe_prg(22'h000456, 1'b0, 8'h00);
    @(negedge clk); bus.prg_req = 1'b0;
    wait_req(1'b1, 20, c);
    check("t6_req_seen", 32'(c >= 0), 1);
    wait_req(1'b0, 400, c);
    check("t6_req_cycles", c, 255);
    @(negedge clk);
    check("t6_timeout_flag", 32'(bus.err_flags), WP ? 32'hD : 32'h9);
    check("t6_prg_rdata", 32'(bus.prg_rdata), 32'hFF);
    check("t6_prg_busy", 32'(bus.prg_busy), 0);

    // Asynchronous reset in the middle of a transaction
    exp_q.push_back('{22'h2000AA, 1'b0, 8'h00});
    @(negedge clk); strobe_chr(22'h2000AA, 1'b0, 8'h00);
    @(negedge clk); bus.chr_req = 1'b0;
    wait_req(1'b1, 20, c);
    #2 reset_n = 1'b0;
    #1;
    check("t7_req_dropped", 32'(bus.mem_req), 0);
    check("t7_chr_busy", 32'(bus.chr_busy), 0);
    check("t7_err_cleared", 32'(bus.err_flags), 0);
    check("t7_chr_rdata", 32'(bus.chr_rdata), 32'hFF);
    @(negedge clk); reset_n = 1'b1;
    resp_withhold = 1'b0;
    repeat (4) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
